// File: rtl/rsa_key_prep.sv
// rtl/rsa_key_prep.sv - N = P*Q and PHI = (P-1)*(Q-1) by bit-serial shift-add, presented with E.
// Optional parity check of P, Q, E enabled by RSA_PREP_ODD_CHECK_EN.
module rsa_key_prep #(
   parameter int WIDTH = 512
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               start,
   input  logic [WIDTH/2-1:0] P,
   input  logic [WIDTH/2-1:0] Q,
   input  logic [WIDTH-1:0]   E,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   N,
   output logic [WIDTH-1:0]   PHI,
   output logic [WIDTH-1:0]   E_out,
   output logic               err
);

   localparam int HALF = WIDTH / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      CHECK,
      HOLD
   } state_t;

   state_t            state_q;
   logic [HALF-1:0]   p_q, q_q, pm1_q, qm1_q;
   logic [WIDTH-1:0]  e_q;
   logic [CW-1:0]     cnt_q;
   logic [WIDTH-1:0]  acc_n_q, acc_phi_q;
   logic [WIDTH-1:0]  acc_n_d, acc_phi_d;
   logic [WIDTH-1:0]  n_q, phi_q, e_out_q;
   logic              err_q, err_d, range_err;
   logic              busy_q, valid_q;

   always_comb begin
      acc_n_d   = acc_n_q;
      acc_phi_d = acc_phi_q;
      if (q_q[cnt_q])
         acc_n_d = acc_n_q + (WIDTH'(p_q) << cnt_q);
      if (qm1_q[cnt_q])
         acc_phi_d = acc_phi_q + (WIDTH'(pm1_q) << cnt_q);
   end

   // Evaluated in CHECK, when acc_phi_q holds the finished totient.
   always_comb begin
      range_err = (p_q < HALF'(2)) || (q_q < HALF'(2)) ||
                  (e_q < WIDTH'(2)) || (e_q >= acc_phi_q);
`ifdef RSA_PREP_ODD_CHECK_EN
      err_d = range_err || !p_q[0] || !q_q[0] || !e_q[0];
`else
      err_d = range_err;
`endif
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         p_q       <= '0;
         q_q       <= '0;
         pm1_q     <= '0;
         qm1_q     <= '0;
         e_q       <= '0;
         cnt_q     <= '0;
         acc_n_q   <= '0;
         acc_phi_q <= '0;
         n_q       <= '0;
         phi_q     <= '0;
         e_out_q   <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  p_q       <= P;
                  q_q       <= Q;
                  e_q       <= E;
                  pm1_q     <= P - HALF'(1);
                  qm1_q     <= Q - HALF'(1);
                  cnt_q     <= '0;
                  acc_n_q   <= '0;
                  acc_phi_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= MUL;
               end
            end
            MUL: begin
               acc_n_q   <= acc_n_d;
               acc_phi_q <= acc_phi_d;
               cnt_q     <= cnt_q + CW'(1);
               if (cnt_q == CW'(HALF - 1))
                  state_q <= CHECK;
            end
            CHECK: begin
               n_q     <= acc_n_q;
               phi_q   <= acc_phi_q;
               e_out_q <= e_q;
               err_q   <= err_d;
               valid_q <= 1'b1;
               state_q <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign N         = n_q;
   assign PHI       = phi_q;
   assign E_out     = e_out_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rsa_key_prep.sv
// tb/tb_rsa_key_prep.sv - randomized and directed checks of rsa_key_prep at WIDTH=16.
module tb_rsa_key_prep;

   localparam int W = 16;
   localparam int H = W / 2;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic         start = 1'b0;
   logic [H-1:0] P = '0, Q = '0;
   logic [W-1:0] E = '0;
   logic         busy, out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] N, PHI, E_out;
   logic         err;

   int tests_run = 0;
   int tests_failed = 0;

   rsa_key_prep #(.WIDTH(W)) dut (
      .aclk(aclk), .aresetn(aresetn), .start(start),
      .P(P), .Q(Q), .E(E),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .N(N), .PHI(PHI), .E_out(E_out), .err(err)
   );

   always #5 aclk = ~aclk;

   function automatic void model(input int p, input int q, input int e,
                                 output int n, output int phi, output bit er);
      n   = p * q;
      phi = ((p - 1) & 255) * ((q - 1) & 255);
      er  = (p < 2) || (q < 2) || (e < 2) || (e >= phi);
`ifdef RSA_PREP_ODD_CHECK_EN
      if ((p % 2) == 0 || (q % 2) == 0 || (e % 2) == 0) er = 1'b1;
`endif
   endfunction

   // Pulse start for one cycle, scramble inputs, then count cycles to out_valid.
   task automatic launch(input int p, input int q, input int e, output int lat);
      @(negedge aclk);
      P = H'(p); Q = H'(q); E = W'(e); start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      P = H'($urandom); Q = H'($urandom); E = W'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge aclk);
         lat++;
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(negedge aclk);
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_release valid=%b busy=%b exp 0 0", tag, out_valid, busy);
      end
   endtask

   task automatic check_op(input string tag, input int p, input int q, input int e);
      int n, phi, lat;
      bit er;
      model(p, q, e, n, phi, er);
      launch(p, q, e, lat);
      tests_run++;
      if (lat != 10) begin
         tests_failed++;
         $display("FAIL %s_latency got %0d exp 10", tag, lat);
      end
      tests_run++;
      if (N !== W'(n) || PHI !== W'(phi) || E_out !== W'(e) || err !== er || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_result N=%0d PHI=%0d E=%0d err=%b busy=%b exp N=%0d PHI=%0d E=%0d err=%b busy=1",
                  tag, N, PHI, E_out, err, busy, n, phi, e, er);
      end
      handshake(tag);
   endtask

   task automatic test_reset;
      #1;
      tests_run++;
      if (busy !== 0 || out_valid !== 0 || N !== 0 || PHI !== 0 || E_out !== 0 || err !== 0) begin
         tests_failed++;
         $display("FAIL reset busy=%b valid=%b N=%0d PHI=%0d E=%0d err=%b exp all 0",
                  busy, out_valid, N, PHI, E_out, err);
      end
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic test_basic;
      check_op("basic", 61, 53, 17);
      check_op("e_ge_phi", 61, 53, 3120);
      check_op("p_one", 1, 53, 17);
      check_op("max_ops", 255, 255, 3);
      check_op("q_zero", 61, 0, 17);
      check_op("e_one", 61, 53, 1);
   endtask

   task automatic test_backpressure;
      int lat;
      logic [W-1:0] n0, phi0, e0;
      logic err0;
      bit stable = 1'b1;
      @(negedge aclk);
      P = 8'd61; Q = 8'd53; E = 16'd17; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      repeat (3) @(negedge aclk);
      P = 8'd11; Q = 8'd13; E = 16'd7; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge aclk);
         lat++;
      end
      n0 = N; phi0 = PHI; e0 = E_out; err0 = err;
      tests_run++;
      if (n0 !== 16'd3233 || phi0 !== 16'd3120 || e0 !== 16'd17 || err0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_result N=%0d PHI=%0d E=%0d err=%b exp 3233 3120 17 0", n0, phi0, e0, err0);
      end
      for (int i = 0; i < 20; i++) begin
         start = (i % 5 == 2);
         P = 8'd7; Q = 8'd5; E = 16'd3;
         @(negedge aclk);
         if (!out_valid || !busy || N !== n0 || PHI !== phi0 || E_out !== e0 || err !== err0)
            stable = 1'b0;
      end
      start = 1'b0;
      tests_run++;
      if (!stable) begin
         tests_failed++;
         $display("FAIL bp_hold_stable got unstable exp stable");
      end
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge aclk);
      out_ready = 1'b0;
      start = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_release valid=%b busy=%b exp 0 0", out_valid, busy);
      end
      repeat (12) @(negedge aclk);
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_start_at_handshake valid=%b busy=%b exp 0 0", out_valid, busy);
      end
   endtask

   task automatic test_reset_abort;
      @(negedge aclk);
      P = 8'd61; Q = 8'd53; E = 16'd17; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      repeat (4) @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      tests_run++;
      if (busy !== 0 || out_valid !== 0 || N !== 0 || PHI !== 0 || E_out !== 0 || err !== 0) begin
         tests_failed++;
         $display("FAIL abort_async busy=%b valid=%b N=%0d PHI=%0d exp all 0", busy, out_valid, N, PHI);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      repeat (12) @(negedge aclk);
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_no_partial valid=%b busy=%b exp 0 0", out_valid, busy);
      end
      check_op("after_abort", 11, 13, 7);
   endtask

   task automatic test_odd_check;
      int lat;
      bit exp_err;
`ifdef RSA_PREP_ODD_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      launch(62, 53, 17, lat);
      tests_run++;
      if (err !== exp_err || N !== 16'd3286 || PHI !== 16'd3172) begin
         tests_failed++;
         $display("FAIL odd_even_p err=%b N=%0d PHI=%0d exp err=%b N=3286 PHI=3172", err, N, PHI, exp_err);
      end
      handshake("odd_even_p");
      launch(61, 53, 16, lat);
      tests_run++;
      if (err !== exp_err || N !== 16'd3233) begin
         tests_failed++;
         $display("FAIL odd_even_e err=%b N=%0d exp err=%b N=3233", err, N, exp_err);
      end
      handshake("odd_even_e");
   endtask

   task automatic test_random;
      int p, q, e, phi;
      for (int i = 0; i < 40; i++) begin
         p = $urandom_range(0, 255);
         q = $urandom_range(0, 255);
         phi = ((p - 1) & 255) * ((q - 1) & 255);
         if (i % 3 == 0)
            e = $urandom_range(0, 65535);
         else
            e = (phi > 3) ? $urandom_range(2, phi - 1) : $urandom_range(0, 4);
         check_op($sformatf("rand%0d", i), p, q, e);
      end
   endtask

   task automatic test_back_to_back;
      check_op("b2b_a", 3, 5, 7);
      check_op("b2b_b", 200, 17, 1001);
      check_op("b2b_c", 2, 2, 2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_abort();
      test_odd_check();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
